// File: rtl/pll_pkg.sv
// Shared PLL types: Q4.12 tuning word format and DCO cell constants.
// Imported by the DCO tune encoder and its thermometer encoder.
package pll_pkg;
  localparam int TUNE_WIDTH  = 16;
  localparam int TUNE_FRAC   = 12;
  localparam int TUNE_INT    = TUNE_WIDTH - TUNE_FRAC;
  localparam int TUNE_OFFSET = 8;
  localparam int NCELLS      = 15;

  typedef logic signed [TUNE_WIDTH-1:0] tune_t;
  typedef logic [TUNE_INT-1:0]          code_t;
  typedef logic [NCELLS-1:0]            cells_t;
endpackage

// File: rtl/therm_encoder.sv
// Combinational count-to-thermometer encoder for the DCO cell bank.
// Ports: count_i (cell count), cells_o (bit i set iff i < count_i).
module therm_encoder
  import pll_pkg::*;
#(
  parameter int CW = TUNE_INT,
  parameter int NC = NCELLS
) (
  input  logic [CW-1:0] count_i,
  output logic [NC-1:0] cells_o
);

  always_comb begin
    cells_o = '0;
    for (int i = 0; i < NC; i++) begin
      cells_o[i] = (CW'(i) < count_i);
    end
  end

endmodule

// File: rtl/dco_tune_encoder.sv
// Q4.12 tuning word to DCO thermometer cell enables, with first-order
// sigma-delta dither of one extra cell driven by the fractional bits.
// Ports: clock/arst_n; tune_in + tune_load capture; sd_en dither enable;
// cells_out/code_out/sat registered outputs; tick marks an update cycle.
module dco_tune_encoder
  import pll_pkg::*;
#(
  parameter int WIDTH     = TUNE_WIDTH,
  parameter int FRAC_BITS = TUNE_FRAC,
  parameter int NCELLS    = pll_pkg::NCELLS,
  parameter int DIV       = 1
) (
  input  logic                    clock,
  input  logic                    arst_n,
  input  logic signed [WIDTH-1:0] tune_in,
  input  logic                    tune_load,
  input  logic                    sd_en,
  output logic [NCELLS-1:0]       cells_out,
  output logic [WIDTH-FRAC_BITS-1:0] code_out,
  output logic                    tick,
  output logic                    sat
);

  localparam int IW = WIDTH - FRAC_BITS;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [IW:0]   OFFSET   = (IW+1)'(1 << (IW - 1));
  localparam logic [IW-1:0] CODE_RST = OFFSET[IW-1:0];
  localparam logic [NCELLS-1:0] CELLS_RST =
    NCELLS'((1 << (1 << (IW - 1))) - 1);

  logic signed [WIDTH-1:0] tune_q;
  logic [FRAC_BITS-1:0]    acc_q, acc_d;
  logic [DW-1:0]           div_q, div_d;
  logic [IW-1:0]           code_q, code_d;
  logic [NCELLS-1:0]       cells_q, cells_d;
  logic                    sat_q, sat_d;
  logic                    tick_q;

  logic                    tick_int;
  logic [FRAC_BITS:0]      sum;
  logic                    carry;
  logic [IW:0]             idx;

  always_comb begin
    tick_int = (div_q == DIV_LAST);
    div_d    = tick_int ? '0 : div_q + 1'b1;
    sum      = {1'b0, acc_q} + {1'b0, tune_q[FRAC_BITS-1:0]};
    carry    = sd_en & sum[FRAC_BITS];
    acc_d    = sd_en ? sum[FRAC_BITS-1:0] : '0;
    // Sign-extended integer part plus offset: range 0..2^IW,
    // so only the top bit can signal overflow past full scale.
    idx      = {tune_q[WIDTH-1], tune_q[WIDTH-1:FRAC_BITS]}
             + OFFSET + {{IW{1'b0}}, carry};
    sat_d    = idx[IW];
    code_d   = sat_d ? '1 : idx[IW-1:0];
  end

  therm_encoder #(
    .CW (IW),
    .NC (NCELLS)
  ) u_therm (
    .count_i (code_d),
    .cells_o (cells_d)
  );

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      tune_q  <= '0;
      acc_q   <= '0;
      div_q   <= '0;
      code_q  <= CODE_RST;
      cells_q <= CELLS_RST;
      sat_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= tick_int;
      div_q  <= div_d;
      if (tune_load) tune_q <= tune_in;
      if (tick_int) begin
        acc_q   <= acc_d;
        code_q  <= code_d;
        cells_q <= cells_d;
        sat_q   <= sat_d;
      end
    end
  end

  assign cells_out = cells_q;
  assign code_out  = code_q;
  assign sat       = sat_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_dco_tune_encoder.sv
// Self-checking bench for dco_tune_encoder (DIV=1 and DIV=4 instances).
// Expected codes are queued on stimulus and popped on each update.
module tb_dco_tune_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic signed [15:0] tin1, tin4;
  logic ld1, ld4, sd1, sd4;
  logic [14:0] cells1, cells4;
  logic [3:0] code1, code4;
  logic tick1, tick4, sat1, sat4;

  int checks = 0;
  int errors = 0;

  // {sat, code}
  logic [4:0] exp_q[$];

  dco_tune_encoder #(.DIV(1)) u1 (
    .clock     (clk),
    .arst_n    (rst_n),
    .tune_in   (tin1),
    .tune_load (ld1),
    .sd_en     (sd1),
    .cells_out (cells1),
    .code_out  (code1),
    .tick      (tick1),
    .sat       (sat1)
  );

  dco_tune_encoder #(.DIV(4)) u4 (
    .clock     (clk),
    .arst_n    (rst_n),
    .tune_in   (tin4),
    .tune_load (ld4),
    .sd_en     (sd4),
    .cells_out (cells4),
    .code_out  (code4),
    .tick      (tick4),
    .sat       (sat4)
  );

  function automatic logic [14:0] therm(input logic [3:0] c);
    logic [15:0] t;
    t = (16'd1 << c) - 16'd1;
    return t[14:0];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    tin1 = '0; tin4 = '0;
    ld1 = 0; ld4 = 0; sd1 = 0; sd4 = 0;
    #1 rst_n = 1'b0;
    #12;
    checks++;
    if (code1 !== 4'd8 || cells1 !== 15'h00FF
        || sat1 !== 1'b0 || tick1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_u1: code=%0d cells=%h sat=%b tick=%b, need 8 00ff 0 0",
               code1, cells1, sat1, tick1);
    end
    checks++;
    if (code4 !== 4'd8 || cells4 !== 15'h00FF
        || sat4 !== 1'b0 || tick4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_u4: code=%0d cells=%h sat=%b tick=%b, need 8 00ff 0 0",
               code4, cells4, sat4, tick4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sd1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (code1 !== 4'd8 || cells1 !== 15'h00FF || tick1 !== 1'b1) begin
        errors++;
        $display("FAIL idle_code: code=%0d cells=%h tick=%b, need 8 00ff 1",
                 code1, cells1, tick1);
      end
    end
  endtask

  task automatic test_load_int();
    logic [4:0] e;
    tin1 = 16'sh1000;
    ld1 = 1'b1;
    step();
    ld1 = 1'b0;
    checks++;
    if (code1 !== 4'd8) begin
      errors++;
      $display("FAIL load_uses_old: code=%0d need 8", code1);
    end
    repeat (4) exp_q.push_back({1'b0, 4'd9});
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (code1 !== e[3:0] || cells1 !== therm(e[3:0])
          || sat1 !== e[4]) begin
        errors++;
        $display("FAIL int_code: code=%0d cells=%h sat=%b, need %0d %h %b",
                 code1, cells1, sat1, e[3:0], therm(e[3:0]), e[4]);
      end
    end
  endtask

  task automatic test_half();
    logic [4:0] e;
    int sum;
    tin1 = 16'sh0800;
    ld1 = 1'b1;
    step();
    ld1 = 1'b0;
    checks++;
    if (code1 !== 4'd9) begin
      errors++;
      $display("FAIL half_load_edge: code=%0d need 9", code1);
    end
    for (int i = 0; i < 64; i++)
      exp_q.push_back({1'b0, (i % 2 == 0) ? 4'd8 : 4'd9});
    sum = 0;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      sum += int'(code1);
      checks++;
      if (code1 !== e[3:0] || cells1 !== therm(e[3:0])) begin
        errors++;
        $display("FAIL half_seq: code=%0d cells=%h, need %0d %h",
                 code1, cells1, e[3:0], therm(e[3:0]));
      end
    end
    checks++;
    if (sum != 544) begin
      errors++;
      $display("FAIL half_mean: sum64=%0d need 544", sum);
    end
  endtask

  task automatic test_sat();
    logic [4:0] e;
    tin1 = 16'sh7FFF;
    ld1 = 1'b1;
    sd1 = 1'b0;
    step();
    ld1 = 1'b0;
    sd1 = 1'b1;
    checks++;
    if (code1 !== 4'd8 || sat1 !== 1'b0) begin
      errors++;
      $display("FAIL sat_pre: code=%0d sat=%b need 8 0", code1, sat1);
    end
    exp_q.push_back({1'b0, 4'd15});
    exp_q.push_back({1'b1, 4'd15});
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (code1 !== e[3:0] || cells1 !== 15'h7FFF || sat1 !== e[4]) begin
        errors++;
        $display("FAIL sat_max: code=%0d cells=%h sat=%b, need %0d 7fff %b",
                 code1, cells1, sat1, e[3:0], e[4]);
      end
    end
    tin1 = 16'sh8000;
    ld1 = 1'b1;
    step();
    ld1 = 1'b0;
    checks++;
    if (sat1 !== 1'b1 || code1 !== 4'd15) begin
      errors++;
      $display("FAIL sat_carry: code=%0d sat=%b need 15 1", code1, sat1);
    end
    repeat (3) exp_q.push_back({1'b0, 4'd0});
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (code1 !== e[3:0] || cells1 !== 15'h0000 || sat1 !== e[4]) begin
        errors++;
        $display("FAIL min_code: code=%0d cells=%h sat=%b, need 0 0000 0",
                 code1, cells1, sat1);
      end
    end
  endtask

  task automatic test_div4();
    logic [4:0] e;
    logic [3:0] cur;
    int nines;
    int guard;
    guard = 0;
    while (tick4 !== 1'b1 && guard < 12) begin
      step();
      guard++;
    end
    checks++;
    if (tick4 !== 1'b1) begin
      errors++;
      $display("FAIL div4_align: tick=%b need 1 within 12 cycles", tick4);
    end
    tin4 = 16'sh0400;
    ld4 = 1'b1;
    sd4 = 1'b1;
    cur = code4;
    nines = 0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, 4'd8});
      exp_q.push_back({1'b0, 4'd8});
      exp_q.push_back({1'b0, 4'd8});
      exp_q.push_back({1'b0, 4'd9});
    end
    exp_q.push_back({1'b0, 4'd8});
    exp_q.push_back({1'b0, 4'd8});
    exp_q.push_back({1'b0, 4'd8});
    exp_q.push_back({1'b0, 4'd8});
    exp_q.push_back({1'b0, 4'd8});
    exp_q.push_back({1'b0, 4'd9});
    for (int ed = 1; ed <= 56; ed++) begin
      step();
      ld4 = 1'b0;
      checks++;
      if (tick4 !== (ed % 4 == 0)) begin
        errors++;
        $display("FAIL div4_tick: edge %0d tick=%b need %b",
                 ed, tick4, (ed % 4 == 0));
      end
      if (ed % 4 == 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL div4_queue: empty at edge %0d", ed);
        end else begin
          e = exp_q.pop_front();
          cur = e[3:0];
          if (code4 !== e[3:0] || cells4 !== therm(e[3:0])
              || sat4 !== e[4]) begin
            errors++;
            $display("FAIL div4_code: edge %0d code=%0d cells=%h, need %0d %h",
                     ed, code4, cells4, e[3:0], therm(e[3:0]));
          end
        end
        if (code4 === 4'd9) nines++;
      end else begin
        checks++;
        if (code4 !== cur) begin
          errors++;
          $display("FAIL div4_hold: edge %0d code=%0d need %0d",
                   ed, code4, cur);
        end
      end
      if (ed == 36) sd4 = 1'b0;
      if (ed == 40) sd4 = 1'b1;
    end
    checks++;
    if (nines != 3) begin
      errors++;
      $display("FAIL div4_nines: count=%0d need 3", nines);
    end
  endtask

  task automatic test_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (code1 !== 4'd8 || cells1 !== 15'h00FF
        || sat1 !== 1'b0 || tick1 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_u1: code=%0d cells=%h sat=%b tick=%b, need 8 00ff 0 0",
               code1, cells1, sat1, tick1);
    end
    checks++;
    if (code4 !== 4'd8 || cells4 !== 15'h00FF
        || sat4 !== 1'b0 || tick4 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_u4: code=%0d cells=%h sat=%b tick=%b, need 8 00ff 0 0",
               code4, cells4, sat4, tick4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int ed = 1; ed <= 4; ed++) begin
      step();
      checks++;
      if (tick4 !== (ed == 4) || code4 !== 4'd8) begin
        errors++;
        $display("FAIL midrst_div4: edge %0d tick=%b code=%0d, need %b 8",
                 ed, tick4, code4, (ed == 4));
      end
      if (ed == 1) begin
        checks++;
        if (tick1 !== 1'b1 || code1 !== 4'd8) begin
          errors++;
          $display("FAIL midrst_div1: tick=%b code=%0d need 1 8",
                   tick1, code1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_int();
    test_half();
    test_sat();
    test_div4();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
